// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Program-counter register and instruction-fetch sequencer for the MIPS core.
//   Holds the word-addressed PC, issues instruction-memory requests, buffers a
//   single returned instruction and hands it to decode over valid/ready.
//   Branch/jump redirects reload the PC and discard any in-flight fetch that
//   they make stale.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   pc_o / pc_inc_i         PC register and the external PC+1 incrementer result
//   stall_i                 hazard stall, blocks issue of new fetches
//   branch_i, branch_pc_i   taken-branch redirect and target (wins over jump)
//   jump_i, jump_pc_i       jump redirect and target
//   imem_req_o/addr_o       fetch request, held with a stable address until ack
//   imem_ack_i/rdata_i      one-cycle response pulse with instruction word
//   instr_valid_o/instr_o   instruction slot to decode, instr_pc_o is its PC
//   id_ready_i              decode accepts when instr_valid_o && id_ready_i
//
// Build option
//   FETCH_PERF_CNT_EN       adds perf_fetch_o (instructions handed to decode)
//                           and perf_wait_o (cycles waiting on imem), both
//                           wrapping 32-bit counters.
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_o,
  input  logic [31:0] pc_inc_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_pc_i,
  input  logic        jump_i,
  input  logic [31:0] jump_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        id_ready_i
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_o,
  output logic [31:0] perf_wait_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        kill_q;
  logic [31:0] buf_data_q, buf_pc_q;

  logic        slot_free, redirect;
  logic [31:0] redirect_pc;
  // Per-cycle actions decoded by the FSM and applied by the datapath.
  logic        start, capture, to_buf, reissue, unload, set_kill, clr_kill;

  assign slot_free   = !instr_valid_o || id_ready_i;
  assign redirect    = branch_i || jump_i;
  // Branch belongs to the older instruction, so it wins over a jump.
  assign redirect_pc = branch_i ? branch_pc_i : jump_pc_i;
  // A request is outstanding exactly while the sequencer sits in FETCH.
  assign imem_req_o  = (state_q == FETCH);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    capture  = 1'b0;
    to_buf   = 1'b0;
    reissue  = 1'b0;
    unload   = 1'b0;
    set_kill = 1'b0;
    clr_kill = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redirect && slot_free && !stall_i) begin
          start   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack_i) begin
          if (redirect || kill_q) begin
            // Stale response: drop it and refetch from the (new) PC.
            clr_kill = 1'b1;
            state_d  = IDLE;
          end else if (slot_free) begin
            capture = 1'b1;
            if (stall_i) state_d = IDLE;
            else         reissue = 1'b1;
          end else begin
            to_buf  = 1'b1;
            state_d = HOLD;
          end
        end else if (redirect) begin
          // Address must stay put until the ack; remember to discard it.
          set_kill = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_d = IDLE;
        end else if (slot_free) begin
          unload  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_o          <= RESET_PC;
      imem_addr_o   <= 32'h0;
      kill_q        <= 1'b0;
      instr_valid_o <= 1'b0;
      instr_o       <= 32'h0;
      instr_pc_o    <= 32'h0;
    end else begin
      if (redirect)               pc_o <= redirect_pc;
      else if (capture || to_buf) pc_o <= pc_inc_i;

      if (start)        imem_addr_o <= pc_o;
      else if (reissue) imem_addr_o <= pc_inc_i;

      if (set_kill)      kill_q <= 1'b1;
      else if (clr_kill) kill_q <= 1'b0;

      // Redirect empties the slot even if decode is ready this cycle.
      if (redirect)              instr_valid_o <= 1'b0;
      else if (capture || unload) instr_valid_o <= 1'b1;
      else if (id_ready_i)       instr_valid_o <= 1'b0;

      if (capture) begin
        instr_o    <= imem_rdata_i;
        instr_pc_o <= imem_addr_o;
      end else if (unload) begin
        instr_o    <= buf_data_q;
        instr_pc_o <= buf_pc_q;
      end
    end
  end

  // NOTE: the hold buffer has no reset; it is only read in HOLD, which is
  // entered solely on the edge that writes it.
  always_ff @(posedge clk) begin
    if (to_buf) begin
      buf_data_q <= imem_rdata_i;
      buf_pc_q   <= imem_addr_o;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic transfer;
  assign transfer = instr_valid_o && id_ready_i && !redirect;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_o <= 32'h0;
      perf_wait_o  <= 32'h0;
    end else begin
      if (transfer)                 perf_fetch_o <= perf_fetch_o + 32'd1;
      if (imem_req_o && !imem_ack_i) perf_wait_o <= perf_wait_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Directed and randomized bench for pc_fetch_unit (RESET_PC = 0x100).
//   A memory responder answers each request after a chosen latency with a
//   word derived from its address; a scoreboard expects decode to see the
//   program stream in order: sequential PCs, restarting at each redirect
//   target. Define FETCH_PERF_CNT_EN to also check the performance counters.
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk, rst_n;
  logic [31:0] pc_o, pc_inc_i;
  logic        stall_i, branch_i, jump_i;
  logic [31:0] branch_pc_i, jump_pc_i;
  logic        imem_req_o, imem_ack_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        instr_valid_o, id_ready_i;
  logic [31:0] instr_o, instr_pc_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_o, perf_wait_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  assign pc_inc_i = pc_o + 32'd1;

  pc_fetch_unit #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_o         (pc_o),
    .pc_inc_i     (pc_inc_i),
    .stall_i      (stall_i),
    .branch_i     (branch_i),
    .branch_pc_i  (branch_pc_i),
    .jump_i       (jump_i),
    .jump_pc_i    (jump_pc_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_ack_i   (imem_ack_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_valid_o(instr_valid_o),
    .instr_o      (instr_o),
    .instr_pc_o   (instr_pc_o),
    .id_ready_i   (id_ready_i)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_o (perf_fetch_o),
    .perf_wait_o  (perf_wait_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder and reference-model state.
  logic        new_req;
  int          cnt, cur_lat, lat;
  bit          rand_lat;
  logic [31:0] held_addr;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch, exp_wait;
  int          n_deliv;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    new_req   = 1'b1;
    cnt       = 0;
    cur_lat   = 1;
    held_addr = 32'h0;
    exp_pc    = RPC;
    exp_fetch = 32'h0;
    exp_wait  = 32'h0;
  endtask

  // Score the current cycle, advance one clock, then drive this cycle's
  // memory response.
  task automatic tick();
    logic redir;
    redir = branch_i || jump_i;
    if (rst_n) begin
      if (imem_req_o && !imem_ack_i) exp_wait++;
      if (instr_valid_o && id_ready_i && !redir) begin
        check("deliver_pc", instr_pc_o, exp_pc);
        check("deliver_instr", instr_o, mem_word(exp_pc));
        exp_pc++;
        exp_fetch++;
        n_deliv++;
      end
      if (redir) exp_pc = branch_i ? branch_pc_i : jump_pc_i;
    end
    @(posedge clk);
    #1;
    if (!rst_n || !imem_req_o) begin
      imem_ack_i   = 1'b0;
      imem_rdata_i = 32'hDEAD_BEEF;
      new_req      = 1'b1;
    end else begin
      if (new_req) begin
        cnt       = 1;
        cur_lat   = rand_lat ? int'($urandom_range(1, 3)) : lat;
        held_addr = imem_addr_o;
        new_req   = 1'b0;
      end else begin
        cnt++;
        check("addr_hold", imem_addr_o, held_addr);
      end
      imem_ack_i   = (cnt >= cur_lat);
      imem_rdata_i = imem_ack_i ? mem_word(imem_addr_o) : 32'hDEAD_BEEF;
      if (imem_ack_i) new_req = 1'b1;
    end
  endtask

  task automatic do_reset(input bit chk_vals);
    stall_i      = 1'b0;
    branch_i     = 1'b0;
    jump_i       = 1'b0;
    branch_pc_i  = 32'h0;
    jump_pc_i    = 32'h0;
    imem_ack_i   = 1'b0;
    imem_rdata_i = 32'h0;
    id_ready_i   = 1'b1;
    lat          = 1;
    rand_lat     = 1'b0;
    model_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    if (chk_vals) begin
      check("rst_pc", pc_o, RPC);
      check("rst_req", imem_req_o, 0);
      check("rst_addr", imem_addr_o, 0);
      check("rst_valid", instr_valid_o, 0);
      check("rst_instr", instr_o, 0);
      check("rst_ipc", instr_pc_o, 0);
`ifdef FETCH_PERF_CNT_EN
      check("rst_perf_fetch", perf_fetch_o, 0);
      check("rst_perf_wait", perf_wait_o, 0);
`endif
    end
    rst_n = 1'b1;
  endtask

  initial begin
    n_deliv = 0;

    // Back-to-back fetch at one-cycle memory latency.
    do_reset(1'b1);
    tick();
    check("t1_req", imem_req_o, 1);
    check("t1_addr0", imem_addr_o, 32'h100);
    tick();
    check("t1_addr1", imem_addr_o, 32'h101);
    check("t1_valid", instr_valid_o, 1);
    check("t1_ipc0", instr_pc_o, 32'h100);
    tick();
    check("t1_addr2", imem_addr_o, 32'h102);
    check("t1_ipc1", instr_pc_o, 32'h101);

    // Decode back-pressure pushes the second response into the hold buffer.
    do_reset(1'b0);
    tick();
    id_ready_i = 1'b0;
    tick();
    check("t2_first", instr_pc_o, 32'h100);
    tick();
    check("t2_hold_req", imem_req_o, 0);
    check("t2_hold_pc", pc_o, 32'h102);
    check("t2_hold_slot", instr_pc_o, 32'h100);
    tick();
    tick();
    check("t2_still_idle", imem_req_o, 0);
    check("t2_still_slot", instr_pc_o, 32'h100);
    id_ready_i = 1'b1;
    tick();
    check("t2_unload_pc", instr_pc_o, 32'h101);
    check("t2_unload_data", instr_o, mem_word(32'h101));
    check("t2_unload_valid", instr_valid_o, 1);
    tick();
    check("t2_refetch_req", imem_req_o, 1);
    check("t2_refetch_addr", imem_addr_o, 32'h102);

    // Branch during a 4-cycle wait kills the stale response.
    do_reset(1'b0);
    lat = 4;
    for (int i = 0; i < 100 && !(imem_req_o && imem_addr_o == 32'h105); i++) tick();
    check("t3_reach_105", imem_addr_o, 32'h105);
    tick();
    branch_i    = 1'b1;
    branch_pc_i = 32'h40;
    tick();
    branch_i = 1'b0;
    check("t3_pc", pc_o, 32'h40);
    check("t3_req_held", imem_req_o, 1);
    check("t3_addr_held", imem_addr_o, 32'h105);
    check("t3_valid_clr", instr_valid_o, 0);
    tick();
    check("t3_ack_due", imem_ack_i, 1);
    tick();
    check("t3_dropped_req", imem_req_o, 0);
    check("t3_dropped_valid", instr_valid_o, 0);
    tick();
    check("t3_new_addr", imem_addr_o, 32'h40);

    // Branch and jump together: branch target wins.
    do_reset(1'b0);
    tick();
    branch_i    = 1'b1;
    branch_pc_i = 32'h40;
    jump_i      = 1'b1;
    jump_pc_i   = 32'h80;
    tick();
    branch_i = 1'b0;
    jump_i   = 1'b0;
    check("t4_pc", pc_o, 32'h40);
    check("t4_req", imem_req_o, 0);
    check("t4_valid", instr_valid_o, 0);
    tick();
    check("t4_addr", imem_addr_o, 32'h40);

    // Stall in FETCH: outstanding ack still captured, no reissue until release.
    do_reset(1'b0);
    lat = 2;
    tick();
    stall_i = 1'b1;
    tick();
    tick();
    check("t5_cap_req", imem_req_o, 0);
    check("t5_cap_ipc", instr_pc_o, 32'h100);
    check("t5_cap_pc", pc_o, 32'h101);
    tick();
    check("t5_stalled", imem_req_o, 0);
    stall_i = 1'b0;
    tick();
    check("t5_resume_addr", imem_addr_o, 32'h101);
    check("t5_resume_req", imem_req_o, 1);

    // PC wrap through the incrementer.
    do_reset(1'b0);
    jump_i    = 1'b1;
    jump_pc_i = 32'hFFFF_FFFF;
    tick();
    jump_i = 1'b0;
    check("t5_wrap_pc", pc_o, 32'hFFFF_FFFF);
    tick();
    check("t5_wrap_addr0", imem_addr_o, 32'hFFFF_FFFF);
    tick();
    check("t5_wrap_addr1", imem_addr_o, 32'h0);
    check("t5_wrap_ipc", instr_pc_o, 32'hFFFF_FFFF);
    check("t5_wrap_pcnext", pc_o, 32'h0);

    // Reset mid-request is asynchronous; a late ack afterwards is ignored.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) tick();
    check("t6_pre_pc", pc_o, 32'h103);
    rst_n = 1'b0;
    #1;
    check("t6_req", imem_req_o, 0);
    check("t6_pc", pc_o, RPC);
    check("t6_valid", instr_valid_o, 0);
`ifdef FETCH_PERF_CNT_EN
    check("t6_perf_fetch", perf_fetch_o, 0);
    check("t6_perf_wait", perf_wait_o, 0);
`endif
    model_reset();
    rst_n        = 1'b1;
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'h0BAD_0BAD;
    tick();
    check("t6_late_valid", instr_valid_o, 0);
    check("t6_late_addr", imem_addr_o, RPC);
    tick();
    check("t6_first_instr", instr_o, mem_word(RPC));

    // Randomized traffic against the stream scoreboard.
    do_reset(1'b0);
    rand_lat = 1'b1;
    n_deliv  = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r           = int'($urandom_range(0, 39));
      id_ready_i  = ($urandom_range(0, 3) != 0);
      stall_i     = ($urandom_range(0, 4) == 0);
      branch_i    = (r == 0 || r == 1);
      jump_i      = (r == 1 || r == 2);
      branch_pc_i = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 255));
      jump_pc_i   = 32'($urandom_range(256, 1023));
      tick();
    end
    branch_i = 1'b0;
    jump_i   = 1'b0;
    check("rand_progress", 32'(n_deliv > 200), 1);
`ifdef FETCH_PERF_CNT_EN
    check("rand_perf_fetch", perf_fetch_o, exp_fetch);
    check("rand_perf_wait", perf_wait_o, exp_wait);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
